// File: rtl/pc_redirect_unit.sv
// Program-counter and fetch-redirect stage.
// Owns the PC, drives the instruction-fetch request, turns EX-stage branch/jump
// decisions into PC redirects and pipeline flushes, holds a redirect that
// arrives while a fetch is still outstanding, and stops fetching on halt.
module pc_redirect_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  input  logic            halt,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            imem_req,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            halted,
  output logic [31:0]     redirect_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] saved_target;
  logic [XLEN-1:0] saved_nxt;
  logic [XLEN-1:0] eff_target;
  logic [31:0]     cnt_nxt;
  logic            redirect;

  // Instruction addresses are word aligned; the low target bits are dropped.
  logic unused_target_bits;
  assign unused_target_bits = ^target[1:0];

  assign redirect   = br_taken | jump;
  assign eff_target = {target[XLEN-1:2], 2'b00};

  // Next-state, next-PC and flush decode; a redirect outranks both halt and stall.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    saved_nxt   = saved_target;
    cnt_nxt     = redirect_cnt;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    unique case (state)
      RUN: begin
        if (redirect) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_nxt     = redirect_cnt + 32'd1;
          if (imem_ready || !imem_req) begin
            pc_nxt = eff_target;
          end else begin
            // Outstanding fetch: keep the address stable, apply target later.
            saved_nxt = eff_target;
            state_nxt = PEND;
          end
        end else if (halt) begin
          state_nxt = HALT;
        end else if (!stall && imem_req && imem_ready) begin
          pc_nxt = pc + XLEN'(4);
        end
      end
      PEND: begin
        // The fetch still in flight is wrong-path; discard whatever it returns.
        flush_if_id = 1'b1;
        if (imem_ready) begin
          pc_nxt    = saved_target;
          state_nxt = RUN;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    if (!rst_n) begin
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  // State, PC, pending target, fetch request and redirect counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      saved_target <= '0;
      imem_req     <= 1'b0;
      halted       <= 1'b0;
      redirect_cnt <= 32'd0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      saved_target <= saved_nxt;
      imem_req     <= (state_nxt != HALT);
      halted       <= (state_nxt == HALT);
      redirect_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the fetch/redirect rules.
module tb_pc_redirect_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_taken, jump, halt, imem_ready;
  logic [31:0] target;
  logic [31:0] pc;
  logic        imem_req, flush_if_id, flush_id_ex, halted;
  logic [31:0] redirect_cnt;

  pc_redirect_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .jump(jump),
    .target(target), .halt(halt), .imem_ready(imem_ready), .pc(pc),
    .imem_req(imem_req), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .halted(halted), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 = running, 1 = waiting to apply a redirect, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_saved, m_cnt;
  logic        m_req, m_halted;

  function automatic void model_reset();
    m_mode = 0; m_pc = RESET_PC; m_saved = 0; m_cnt = 0; m_req = 0; m_halted = 0;
  endfunction

  function automatic logic exp_fif();
    if (!rst_n) return 1'b0;
    if (m_mode == 1) return 1'b1;
    return (m_mode == 0) && (br_taken || jump);
  endfunction

  function automatic logic exp_fie();
    if (!rst_n) return 1'b0;
    return (m_mode == 0) && (br_taken || jump);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (br_taken || jump) begin
        m_cnt = m_cnt + 1;
        if (imem_ready || !m_req) m_pc = target & ~32'd3;
        else begin m_saved = target & ~32'd3; m_mode = 1; end
      end else if (halt) m_mode = 2;
      else if (!stall && m_req && imem_ready) m_pc = m_pc + 4;
    end else if (m_mode == 1) begin
      if (imem_ready) begin m_pc = m_saved; m_mode = 0; end
    end
    m_req    = (m_mode != 2);
    m_halted = (m_mode == 2);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; jump = 0; halt = 0; imem_ready = 1; target = 0;
  endtask

  // Unconditional redirect with memory ready, used to place the PC.
  task automatic go(input logic [31:0] t);
    idle_inputs();
    jump = 1; target = t;
    tick();
    jump = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    br_taken = 1; jump = 1; target = 32'h44;
    rst_n = 0;
    model_reset();
    #12;
    n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, RESET_PC); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    n_checks++; if (halted !== 1'b0 || redirect_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_halt_cnt got=%b/%h exp=0/0", halted, redirect_cnt); end
    n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_fail++; $display("FAIL reset_flush got=%b exp=00", {flush_if_id, flush_id_ex}); end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL release_req got=%b exp=0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || pc !== 32'd0) begin n_fail++; $display("FAIL first_edge got req=%b pc=%h exp req=1 pc=0", imem_req, pc); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_fetch%0d got=%h exp=%h", i, pc, 32'(i * 4)); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] cnt0;
    go(32'h20);
    cnt0 = redirect_cnt;
    br_taken = 1; target = 32'h100; imem_ready = 1;
    #1;
    n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_fail++; $display("FAIL branch_flush got=%b exp=11", {flush_if_id, flush_id_ex}); end
    tick();
    br_taken = 0;
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL branch_pc got=%h exp=00000100", pc); end
    n_checks++; if (redirect_cnt !== cnt0 + 1) begin n_fail++; $display("FAIL branch_cnt got=%0d exp=%0d", redirect_cnt, cnt0 + 1); end
  endtask

  task automatic test_pending();
    go(32'h40);
    imem_ready = 0; jump = 1; target = 32'h203;
    #1;
    n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_fail++; $display("FAIL pend_entry_flush got=%b exp=11", {flush_if_id, flush_id_ex}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      // Younger instructions are wrong-path; these must be ignored.
      jump = 1'(i & 1); br_taken = 1; halt = 1'(i == 1); target = 32'h7777_0000;
      #1;
      n_checks++; if (pc !== 32'h40 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b0) begin
        n_fail++; $display("FAIL pend_hold%0d got pc=%h fif=%b fie=%b exp pc=40 fif=1 fie=0", i, pc, flush_if_id, flush_id_ex);
      end
      tick();
    end
    jump = 0; br_taken = 0; halt = 0; imem_ready = 1;
    tick();
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL pend_apply got=%h exp=00000200", pc); end
    n_checks++; if (flush_if_id !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL pend_exit got fif=%b halted=%b exp 0/0", flush_if_id, halted); end
    tick();
    n_checks++; if (pc !== 32'h204) begin n_fail++; $display("FAIL pend_resume got=%h exp=00000204", pc); end
  endtask

  task automatic test_stall();
    idle_inputs();
    stall = 1; br_taken = 1; target = 32'h80;
    #1;
    n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_fail++; $display("FAIL stall_redir_flush got=%b exp=11", {flush_if_id, flush_id_ex}); end
    tick();
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL stall_redir_pc got=%h exp=00000080", pc); end
    br_taken = 0;
    #1;
    n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_fail++; $display("FAIL stall_flush got=%b exp=00", {flush_if_id, flush_id_ex}); end
    tick(); tick();
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL stall_hold got=%h exp=00000080", pc); end
    stall = 0;
  endtask

  task automatic test_wrap();
    go(32'hFFFF_FFFC);
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got=%h exp=00000000", pc); end
  endtask

  task automatic test_halt();
    go(32'h60);
    halt = 1;
    tick();
    halt = 0;
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h60) begin
      n_fail++; $display("FAIL halt_enter got halted=%b req=%b pc=%h exp 1/0/60", halted, imem_req, pc);
    end
    br_taken = 1; target = 32'h300;
    #1;
    n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_fail++; $display("FAIL halt_flush got=%b exp=00", {flush_if_id, flush_id_ex}); end
    tick(); tick();
    n_checks++; if (pc !== 32'h60 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_frozen got pc=%h halted=%b exp 60/1", pc, halted); end
    br_taken = 0;
    rst_n = 0;
    model_reset();
    #2;
    n_checks++; if (pc !== RESET_PC || halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got pc=%h halted=%b exp %h/0", pc, halted, RESET_PC); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset_in_pend();
    tick(); // imem_req becomes 1
    go(32'h40);
    imem_ready = 0; jump = 1; target = 32'h500;
    tick();
    jump = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (pc !== RESET_PC || {flush_if_id, flush_id_ex} !== 2'b00 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL pend_reset got pc=%h flush=%b req=%b exp %h/00/0", pc, {flush_if_id, flush_id_ex}, imem_req, RESET_PC);
    end
    @(posedge clk); #1;
    rst_n = 1; imem_ready = 1;
    #1;
    n_checks++; if (flush_if_id !== 1'b0) begin n_fail++; $display("FAIL pend_reset_state got fif=%b exp=0", flush_if_id); end
    tick();
    n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL pend_reset_discard got=%h exp=%h", pc, RESET_PC); end
    tick();
    n_checks++; if (pc !== RESET_PC + 4) begin n_fail++; $display("FAIL pend_reset_fetch got=%h exp=%h", pc, RESET_PC + 4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 99) >= 2);
      stall      = ($urandom_range(0, 3) == 0);
      br_taken   = ($urandom_range(0, 5) == 0);
      jump       = ($urandom_range(0, 9) == 0);
      halt       = ($urandom_range(0, 39) == 0);
      imem_ready = ($urandom_range(0, 1) == 1);
      target     = $urandom;
      #1;
      n_checks++; if (flush_if_id !== exp_fif() || flush_id_ex !== exp_fie()) begin
        n_fail++; $display("FAIL rand_flush%0d got=%b%b exp=%b%b", i, flush_if_id, flush_id_ex, exp_fif(), exp_fie());
      end
      tick();
      n_checks++; if (pc !== m_pc || imem_req !== m_req || halted !== m_halted || redirect_cnt !== m_cnt) begin
        n_fail++; $display("FAIL rand_state%0d got pc=%h req=%b halted=%b cnt=%0d exp pc=%h req=%b halted=%b cnt=%0d",
                           i, pc, imem_req, halted, redirect_cnt, m_pc, m_req, m_halted, m_cnt);
      end
    end
    rst_n = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_branch();
    test_pending();
    test_stall();
    test_wrap();
    test_halt();
    test_reset_in_pend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
